// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with majority vote and ready/valid output.
// Define UART_RX_FIFO_EN to replace the holding register with a FIFO_DEPTH FIFO.
module uart_rx_os #(
  parameter int CLOCK_HZ   = 25_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_perr,
  output logic                 m_ferr,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TICK_DIV = CLOCK_HZ / (BAUD * OVERSAMPLE);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int OW = DATA_BITS + 2;

  localparam logic [PW-1:0] P_LOAD = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_M0 = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_M1 = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_M2 = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
      DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      TICK_DIV < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_rx_os: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } state_t;

  logic                 sync1_q, sync2_q, prev_q;
  state_t               state_q, state_d;
  logic [PW-1:0]        pre_q, pre_d;
  logic [SW-1:0]        s_q, s_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [2:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shf_q, shf_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  logic start_edge, tick, bit_end, mid_smp;
  logic live_maj, bit_maj, par_exp;
  logic commit, c_ferr;

  // Two-flop synchroniser plus a delayed copy for fall detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign start_edge = prev_q & ~sync2_q;
  assign tick       = (state_q != ST_IDLE) && (pre_q == '0);
  assign bit_end    = tick && (s_q == S_LAST);
  assign mid_smp    = (s_q == S_M0) || (s_q == S_M1) || (s_q == S_M2);
  assign live_maj   = (smp_q[1] & smp_q[0]) | (smp_q[1] & sync2_q) |
                      (smp_q[0] & sync2_q);
  assign bit_maj    = (smp_q[2] & smp_q[1]) | (smp_q[2] & smp_q[0]) |
                      (smp_q[1] & smp_q[0]);
  assign par_exp    = (PARITY == 1) ? ~(^shf_q) : (^shf_q);
  assign c_ferr     = ferr_q | ~live_maj;
  assign busy       = (state_q != ST_IDLE);

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      s_q     <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      smp_q   <= '0;
      shf_q   <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      s_q     <= s_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      smp_q   <= smp_d;
      shf_q   <= shf_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Prescaler, sample counter, majority capture and frame FSM.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    s_d     = s_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    smp_d   = smp_q;
    shf_d   = shf_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    commit  = 1'b0;

    if (state_q != ST_IDLE) begin
      pre_d = tick ? P_LOAD : pre_q - PW'(1);
    end
    if (tick) begin
      s_d = (s_q == S_LAST) ? '0 : s_q + SW'(1);
      if (mid_smp) begin
        smp_d = {smp_q[1:0], sync2_q};
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_START;
          pre_d   = P_LOAD;
          s_d     = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = bit_maj ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shf_d = {bit_maj, shf_q[DATA_BITS-1:1]};
          bit_d = bit_q + BW'(1);
          if (bit_q == B_LAST) begin
            state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
          end
        end
      end
      ST_PAR: begin
        if (bit_end) begin
          perr_d  = (bit_maj != par_exp);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick && (s_q == S_M2)) begin
          ferr_d = c_ferr;
          if (stop_q == STOP_LAST) begin
            commit  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        if (bit_end) begin
          stop_d = ~stop_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [OW-1:0] mem_q [FIFO_DEPTH];
  logic [OW-1:0] mem_d [FIFO_DEPTH];
  logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
  logic          ovr_q, ovr_d;
  logic          empty, full, pop, push;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop   = !empty && m_ready;
  assign push  = commit && (!full || pop);

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      ovr_q <= 1'b0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ovr_q <= ovr_d;
    end
  end

  // Push committed words, pop on handshake, flag drops when full.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
    wp_d  = wp_q;
    rp_d  = rp_q;
    ovr_d = commit && full && !pop;
    if (push) begin
      mem_d[wp_q[AW-1:0]] = {shf_q, perr_q, c_ferr};
      wp_d = wp_q + (AW+1)'(1);
    end
    if (pop) begin
      rp_d = rp_q + (AW+1)'(1);
    end
  end

  assign {m_data, m_perr, m_ferr} = mem_q[rp_q[AW-1:0]];
  assign m_valid = !empty;
  assign overrun = ovr_q;
`else
  logic [OW-1:0] hold_q, hold_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;

  // Single holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  // Load when empty or draining this cycle, otherwise drop and flag.
  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (commit) begin
      if (!valid_q || m_ready) begin
        hold_d  = {shf_q, perr_q, c_ferr};
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && m_ready) begin
      valid_d = 1'b0;
    end
  end

  assign {m_data, m_perr, m_ferr} = hold_q;
  assign m_valid = valid_q;
  assign overrun = ovr_q;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed bench for uart_rx_os at 32 clocks per bit.
// Covers 8N1, even parity, framing, glitch, break, overrun and reset.
module tb_uart_rx_os;

  localparam int CLK_HZ = 3_686_400;
  localparam int BIT    = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1, rx_p = 1'b1;
  logic       rdy = 1'b1, rdy_p = 1'b1;
  logic [7:0] data, data_p;
  logic       perr, ferr, valid, ovr, busy;
  logic       perr_p, ferr_p, valid_p, ovr_p, busy_p;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  int base;
  logic [9:0] w;
  logic [9:0] q [$];
  logic [9:0] qp [$];

  always #5 clk = ~clk;

  uart_rx_os #(
    .CLOCK_HZ(CLK_HZ), .BAUD(115_200), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .serial_in(rx),
    .m_data(data), .m_perr(perr), .m_ferr(ferr),
    .m_valid(valid), .m_ready(rdy),
    .overrun(ovr), .busy(busy)
  );

  uart_rx_os #(
    .CLOCK_HZ(CLK_HZ), .BAUD(115_200), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .serial_in(rx_p),
    .m_data(data_p), .m_perr(perr_p), .m_ferr(ferr_p),
    .m_valid(valid_p), .m_ready(rdy_p),
    .overrun(ovr_p), .busy(busy_p)
  );

  // Record accepted words and overrun pulses mid-cycle.
  always @(negedge clk) begin
    if (valid && rdy) q.push_back({ferr, perr, data});
    if (valid_p && rdy_p) qp.push_back({ferr_p, perr_p, data_p});
    if (ovr) ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit p, input logic b);
    if (p) rx_p = b;
    else rx = b;
  endtask

  task automatic send(input bit p, input logic [7:0] d, input bit has_par,
                      input logic pb, input logic sb);
    drive(p, 1'b0);
    wclk(BIT);
    for (int i = 0; i < 8; i++) begin
      drive(p, d[i]);
      wclk(BIT);
    end
    if (has_par) begin
      drive(p, pb);
      wclk(BIT);
    end
    drive(p, sb);
    wclk(BIT);
    drive(p, 1'b1);
    wclk(BIT);
  endtask

  task automatic take(input bit p, output logic [9:0] r);
    r = 'x;
    if (p) begin
      if (qp.size() > 0) r = qp.pop_front();
    end else begin
      if (q.size() > 0) r = q.pop_front();
    end
  endtask

  initial begin
    wclk(3);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_flags", 32'({perr, ferr}), 0);
    chk("rst_ovr", 32'(ovr), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    wclk(4);

    send(0, 8'hA5, 0, 1'b0, 1'b1);
    wclk(4);
    chk("t1_beats", q.size(), 1);
    take(0, w);
    chk("t1_data", 32'(w[7:0]), 32'hA5);
    chk("t1_perr", 32'(w[8]), 0);
    chk("t1_ferr", 32'(w[9]), 0);
    chk("t1_valid_low", 32'(valid), 0);

    send(1, 8'h07, 1, 1'b0, 1'b1);
    wclk(4);
    chk("t2_beats", qp.size(), 1);
    take(1, w);
    chk("t2_data", 32'(w[7:0]), 32'h07);
    chk("t2_perr", 32'(w[8]), 1);
    chk("t2_ferr", 32'(w[9]), 0);
    send(1, 8'h07, 1, 1'b1, 1'b1);
    wclk(4);
    take(1, w);
    chk("t2_good_par", 32'(w), 32'h007);

    send(0, 8'h3C, 0, 1'b0, 1'b0);
    send(0, 8'h11, 0, 1'b0, 1'b1);
    wclk(4);
    chk("t3_beats", q.size(), 2);
    take(0, w);
    chk("t3_ferr_word", 32'(w), 32'h23C);
    take(0, w);
    chk("t3_clean_word", 32'(w), 32'h011);

    rx = 1'b0;
    wclk(6);
    chk("t4_busy_hi", 32'(busy), 1);
    wclk(6);
    rx = 1'b1;
    wclk(28);
    chk("t4_busy_lo", 32'(busy), 0);
    wclk(2 * BIT);
    chk("t4_no_word", q.size(), 0);

    rx = 1'b0;
    wclk(11 * BIT);
    chk("brk_idle", 32'(busy), 0);
    wclk(BIT);
    rx = 1'b1;
    wclk(2 * BIT);
    chk("brk_beats", q.size(), 1);
    take(0, w);
    chk("brk_word", 32'(w), 32'h200);

    rdy = 1'b0;
    base = ovr_cnt;
`ifdef UART_RX_FIFO_EN
    for (int i = 1; i <= 5; i++) send(0, 8'(i), 0, 1'b0, 1'b1);
    chk("t5_ovr", ovr_cnt - base, 1);
    chk("t5_valid", 32'(valid), 1);
    chk("t5_head", 32'(data), 1);
    rdy = 1'b1;
    wclk(8);
    chk("t5_beats", q.size(), 4);
    for (int i = 1; i <= 4; i++) begin
      take(0, w);
      chk("t5_fifo_word", 32'(w), 32'(i));
    end
`else
    send(0, 8'h01, 0, 1'b0, 1'b1);
    send(0, 8'h02, 0, 1'b0, 1'b1);
    chk("t5_ovr", ovr_cnt - base, 1);
    chk("t5_valid", 32'(valid), 1);
    chk("t5_hold", 32'(data), 1);
    rdy = 1'b1;
    wclk(4);
    chk("t5_beats", q.size(), 1);
    take(0, w);
    chk("t5_word", 32'(w), 32'h001);
`endif

    rx = 1'b0;
    wclk(BIT);
    rx = 1'b1;
    wclk(3 * BIT + 10);
    rst_n = 1'b0;
    wclk(2);
    chk("t6_valid", 32'(valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_data", 32'(data), 0);
    chk("t6_ovr", 32'(ovr), 0);
    rst_n = 1'b1;
    wclk(8 * BIT);
    chk("t6_no_word", q.size(), 0);
    send(0, 8'h5A, 0, 1'b0, 1'b1);
    wclk(4);
    chk("t6_beats", q.size(), 1);
    take(0, w);
    chk("t6_word", 32'(w), 32'h05A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
